// File: rtl/posi_md_ram_ctrl.sv
// Single-port RAM controller: arbitrates write/read requests with one-cycle
// read anti-starvation and can zero-fill the whole RAM on request.
module posi_md_ram_ctrl #(
  parameter int ADR_WD = 6,
  parameter int ADR    = 64,
  parameter int DAT_WD = 6
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr_start_i,
  output logic              clr_done_o,
  input  logic              wr_val_i,
  output logic              wr_rdy_o,
  input  logic [ADR_WD-1:0] wr_adr_i,
  input  logic [DAT_WD-1:0] wr_dat_i,
  input  logic              rd_val_i,
  output logic              rd_rdy_o,
  input  logic [ADR_WD-1:0] rd_adr_i,
  output logic [DAT_WD-1:0] rd_dat_o,
  output logic              rd_dat_val_o,
  output logic [ADR_WD-1:0] ram_adr_o,
  output logic [DAT_WD-1:0] ram_wr_dat_o,
  output logic              ram_wr_ena_o,
  output logic              ram_rd_ena_o,
  input  logic [DAT_WD-1:0] ram_rd_dat_i,
  output logic              busy_o
);

  localparam logic [ADR_WD-1:0] LAST_ADR = ADR_WD'(ADR - 1);

  typedef enum logic {SERVE, CLEAR} state_t;

  state_t            state;
  state_t            state_nxt;
  logic [ADR_WD-1:0] clr_adr;
  logic [ADR_WD-1:0] adr_q;
  logic [DAT_WD-1:0] dat_q;
  logic              starved;
  logic              rd_pend;
  logic              wr_acc;
  logic              rd_acc;

  always_ff @(posedge clk) begin
    if (rst) state <= SERVE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      SERVE:   if (clr_start_i) state_nxt = CLEAR;
      CLEAR:   if (clr_adr == LAST_ADR) state_nxt = SERVE;
      default: state_nxt = SERVE;
    endcase
  end

  // While reset is asserted no request is granted and the RAM is left alone,
  // so an aborted fill never touches the address it was about to write.
  always_comb begin
    wr_rdy_o     = 1'b0;
    rd_rdy_o     = 1'b0;
    wr_acc       = 1'b0;
    rd_acc       = 1'b0;
    ram_adr_o    = adr_q;
    ram_wr_dat_o = dat_q;
    ram_wr_ena_o = 1'b1;
    ram_rd_ena_o = 1'b1;
    busy_o       = (state == CLEAR);
    if (!rst) begin
      if (state == CLEAR) begin
        ram_adr_o    = clr_adr;
        ram_wr_dat_o = '0;
        ram_wr_ena_o = 1'b0;
      end else if (!clr_start_i) begin
        wr_rdy_o = !(starved && rd_val_i);
        rd_rdy_o = !wr_val_i || starved;
        wr_acc   = wr_val_i && wr_rdy_o;
        rd_acc   = rd_val_i && rd_rdy_o;
        if (wr_acc) begin
          ram_adr_o    = wr_adr_i;
          ram_wr_dat_o = wr_dat_i;
          ram_wr_ena_o = 1'b0;
        end else if (rd_acc) begin
          ram_adr_o    = rd_adr_i;
          ram_rd_ena_o = 1'b0;
        end
      end
    end
  end

  // rd_pend marks the cycle in which the RAM presents data for a read
  // accepted one cycle earlier; that data is registered onto rd_dat_o.
  always_ff @(posedge clk) begin
    if (rst) begin
      clr_adr      <= '0;
      clr_done_o   <= 1'b0;
      starved      <= 1'b0;
      rd_pend      <= 1'b0;
      rd_dat_o     <= '0;
      rd_dat_val_o <= 1'b0;
      adr_q        <= '0;
      dat_q        <= '0;
    end else begin
      clr_adr      <= (state == CLEAR && clr_adr != LAST_ADR) ? clr_adr + ADR_WD'(1) : '0;
      clr_done_o   <= (state == CLEAR && clr_adr == LAST_ADR);
      starved      <= rd_val_i && !rd_rdy_o;
      rd_pend      <= rd_acc;
      rd_dat_val_o <= rd_pend;
      if (rd_pend) rd_dat_o <= ram_rd_dat_i;
      if (!ram_wr_ena_o || !ram_rd_ena_o) begin
        adr_q <= ram_adr_o;
        dat_q <= ram_wr_dat_o;
      end
    end
  end

endmodule

// File: tb/tb_posi_md_ram_ctrl.sv
// Bench for posi_md_ram_ctrl: directed scenarios with literal expectations,
// then random traffic checked every cycle against a request-level model.
module tb_posi_md_ram_ctrl;

  localparam int AW = 6;
  localparam int N  = 64;
  localparam int DW = 6;

  localparam int K_RDDAT = 0;
  localparam int K_WRRDY = 1;
  localparam int K_RDRDY = 2;
  localparam int K_BUSY  = 3;
  localparam int K_DONE  = 4;
  localparam int K_ADR   = 5;
  localparam int K_WENA  = 6;
  localparam int LIT_MAX = 128;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          clr_start_i = 1'b0;
  logic          clr_done_o;
  logic          wr_val_i = 1'b0;
  logic          wr_rdy_o;
  logic [AW-1:0] wr_adr_i = '0;
  logic [DW-1:0] wr_dat_i = '0;
  logic          rd_val_i = 1'b0;
  logic          rd_rdy_o;
  logic [AW-1:0] rd_adr_i = '0;
  logic [DW-1:0] rd_dat_o;
  logic          rd_dat_val_o;
  logic [AW-1:0] ram_adr_o;
  logic [DW-1:0] ram_wr_dat_o;
  logic          ram_wr_ena_o;
  logic          ram_rd_ena_o;
  logic [DW-1:0] ram_rd_dat_i;
  logic          busy_o;

  always #5 clk = ~clk;

  posi_md_ram_ctrl #(.ADR_WD(AW), .ADR(N), .DAT_WD(DW)) dut (
    .clk          (clk),
    .rst          (rst),
    .clr_start_i  (clr_start_i),
    .clr_done_o   (clr_done_o),
    .wr_val_i     (wr_val_i),
    .wr_rdy_o     (wr_rdy_o),
    .wr_adr_i     (wr_adr_i),
    .wr_dat_i     (wr_dat_i),
    .rd_val_i     (rd_val_i),
    .rd_rdy_o     (rd_rdy_o),
    .rd_adr_i     (rd_adr_i),
    .rd_dat_o     (rd_dat_o),
    .rd_dat_val_o (rd_dat_val_o),
    .ram_adr_o    (ram_adr_o),
    .ram_wr_dat_o (ram_wr_dat_o),
    .ram_wr_ena_o (ram_wr_ena_o),
    .ram_rd_ena_o (ram_rd_ena_o),
    .ram_rd_dat_i (ram_rd_dat_i),
    .busy_o       (busy_o)
  );

  function automatic logic [DW-1:0] init_val(input int i);
    return DW'((i * 37 + 11) % 64);
  endfunction

  // Single-port RAM attached to the controller pins, one-cycle read latency.
  logic [DW-1:0] ram [N];
  logic [DW-1:0] ram_q = '0;
  bit            ram_ready = 1'b0;

  always @(posedge clk) begin
    if (!ram_ready) begin
      for (int i = 0; i < N; i++) ram[i] <= init_val(i);
      ram_ready <= 1'b1;
    end else begin
      if (!ram_wr_ena_o) ram[ram_adr_o] <= ram_wr_dat_o;
      if (!ram_rd_ena_o) ram_q <= ram[ram_adr_o];
    end
  end

  assign ram_rd_dat_i = ram_q;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  int lit_due  [LIT_MAX];
  int lit_kind [LIT_MAX];
  int lit_val  [LIT_MAX];
  int lit_n = 0;

  task automatic checkOutput(input string name, input int act, input int want);
    n_checks++;
    if (act != want) begin
      n_fail++;
      $display("[TB] FAIL %s at cycle %0d: got %0d expected %0d", name, cyc, act, want);
    end
  endtask

  // Request-level reference model: memory contents, pending read results
  // and the fill progress, all advanced once per cycle.
  typedef struct {int due; logic [DW-1:0] d;} rd_t;
  rd_t           rdq[$];
  rd_t           rd_e;
  logic [DW-1:0] m_mem [N];
  bit            m_init = 1'b0;
  bit            m_clearing, m_starved, m_done;
  int            m_idx, m_last_adr, m_last_dat, m_rd_dat;
  bit            e_val, wr_go, rd_go, e_wena, e_rena;
  int            e_adr, e_dat;

  always @(negedge clk) begin
    if (!m_init) begin
      for (int i = 0; i < N; i++) m_mem[i] = init_val(i);
      m_init = 1'b1;
    end
    if (rst) begin
      m_clearing = 0; m_idx = 0; m_starved = 0; m_done = 0;
      m_last_adr = 0; m_last_dat = 0; m_rd_dat = 0;
      rdq.delete();
    end else begin
      e_val = 0;
      if (rdq.size() > 0 && rdq[0].due == cyc) begin
        e_val = 1;
        m_rd_dat = rdq[0].d;
        void'(rdq.pop_front());
      end
      checkOutput("rd_dat_val_o", rd_dat_val_o, e_val);
      checkOutput("rd_dat_o", rd_dat_o, m_rd_dat);
      checkOutput("clr_done_o", clr_done_o, m_done);
      checkOutput("busy_o", busy_o, m_clearing);

      wr_go = 0; rd_go = 0; e_wena = 1; e_rena = 1;
      e_adr = m_last_adr; e_dat = m_last_dat;
      if (m_clearing) begin
        e_adr = m_idx; e_dat = 0; e_wena = 0;
      end else if (!clr_start_i) begin
        if (wr_val_i && rd_val_i) begin
          if (m_starved) rd_go = 1;
          else           wr_go = 1;
        end else begin
          wr_go = wr_val_i;
          rd_go = rd_val_i;
        end
        if (wr_go) begin e_adr = wr_adr_i; e_dat = wr_dat_i; e_wena = 0; end
        if (rd_go) begin e_adr = rd_adr_i; e_rena = 0; end
      end
      if (m_clearing || clr_start_i) begin
        checkOutput("wr_rdy_o blocked", wr_rdy_o, 0);
        checkOutput("rd_rdy_o blocked", rd_rdy_o, 0);
      end else begin
        if (wr_val_i) checkOutput("wr_rdy_o", wr_rdy_o, wr_go);
        if (rd_val_i) checkOutput("rd_rdy_o", rd_rdy_o, rd_go);
      end
      checkOutput("ram_wr_ena_o", ram_wr_ena_o, e_wena);
      checkOutput("ram_rd_ena_o", ram_rd_ena_o, e_rena);
      checkOutput("ram_adr_o", ram_adr_o, e_adr);
      checkOutput("ram_wr_dat_o", ram_wr_dat_o, e_dat);

      m_done = 0;
      if (m_clearing) begin
        m_mem[m_idx] = '0;
        m_idx++;
        if (m_idx == N) begin m_clearing = 0; m_done = 1; end
      end else if (clr_start_i) begin
        m_clearing = 1; m_idx = 0;
      end
      if (wr_go) m_mem[wr_adr_i] = wr_dat_i;
      if (rd_go) begin
        rd_e.due = cyc + 2;
        rd_e.d   = m_mem[rd_adr_i];
        rdq.push_back(rd_e);
      end
      m_starved = rd_val_i && !rd_go;
      if (!e_wena || !e_rena) begin m_last_adr = e_adr; m_last_dat = e_dat; end
    end

    for (int i = 0; i < lit_n; i++) begin
      if (lit_due[i] == cyc) begin
        case (lit_kind[i])
          K_RDDAT: begin
            checkOutput("lit rd_dat_val_o", rd_dat_val_o, 1);
            checkOutput("lit rd_dat_o", rd_dat_o, lit_val[i]);
          end
          K_WRRDY: checkOutput("lit wr_rdy_o", wr_rdy_o, lit_val[i]);
          K_RDRDY: checkOutput("lit rd_rdy_o", rd_rdy_o, lit_val[i]);
          K_BUSY:  checkOutput("lit busy_o", busy_o, lit_val[i]);
          K_DONE:  checkOutput("lit clr_done_o", clr_done_o, lit_val[i]);
          K_ADR:   checkOutput("lit ram_adr_o", ram_adr_o, lit_val[i]);
          K_WENA:  checkOutput("lit ram_wr_ena_o", ram_wr_ena_o, lit_val[i]);
          default: ;
        endcase
      end
    end
    cyc++;
  end

  task automatic applyStimulus(input bit r, input bit cs, input bit wv, input int wa,
                               input int wd, input bit rv, input int ra);
    @(posedge clk);
    #1;
    rst         = r;
    clr_start_i = cs;
    wr_val_i    = wv;
    wr_adr_i    = AW'(wa);
    wr_dat_i    = DW'(wd);
    rd_val_i    = rv;
    rd_adr_i    = AW'(ra);
  endtask

  task automatic expectLit(input int dly, input int kind, input int val);
    if (lit_n < LIT_MAX) begin
      lit_due[lit_n]  = cyc + dly;
      lit_kind[lit_n] = kind;
      lit_val[lit_n]  = val;
      lit_n++;
    end
  endtask

  task automatic idle(input int n);
    repeat (n) applyStimulus(0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL timeout: simulation did not complete");
    $fatal(1, "[TB] timeout");
  end

  int s;
  bit r, cs, wv, rv;
  int wa, wd, ra;

  initial begin
    applyStimulus(1, 0, 0, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 0, 0, 0);
    expectLit(0, K_BUSY, 0);
    expectLit(0, K_DONE, 0);
    expectLit(0, K_ADR, 0);
    expectLit(0, K_WENA, 1);

    // Write then read back one word; data lands two cycles after acceptance.
    applyStimulus(0, 0, 1, 5, 'h2A, 0, 0);
    applyStimulus(0, 0, 0, 0, 0, 1, 5);
    expectLit(2, K_RDDAT, 'h2A);
    idle(3);

    for (int k = 1; k <= 3; k++) applyStimulus(0, 0, 1, k, k * 17, 0, 0);
    for (int k = 1; k <= 3; k++) begin
      applyStimulus(0, 0, 0, 0, 0, 1, k);
      expectLit(2, K_RDDAT, k * 17);
    end
    idle(3);

    // Both requesters held valid: grants alternate starting with the write.
    for (int k = 0; k < 6; k++) begin
      applyStimulus(0, 0, 1, 10 + k, k, 1, 20 + k);
      expectLit(0, K_WRRDY, (k % 2 == 0) ? 1 : 0);
      expectLit(0, K_RDRDY, (k % 2 == 1) ? 1 : 0);
    end
    idle(3);

    // Fill request collides with both requests; then the full 64-cycle fill.
    applyStimulus(0, 1, 1, 7, 9, 1, 7);
    expectLit(0, K_WRRDY, 0);
    expectLit(0, K_RDRDY, 0);
    expectLit(0, K_WENA, 1);
    expectLit(1, K_BUSY, 1);
    expectLit(1, K_ADR, 0);
    expectLit(1, K_WENA, 0);
    expectLit(64, K_BUSY, 1);
    expectLit(64, K_ADR, 63);
    expectLit(64, K_DONE, 0);
    expectLit(65, K_DONE, 1);
    expectLit(65, K_BUSY, 0);
    expectLit(66, K_DONE, 0);
    idle(65);
    applyStimulus(0, 0, 0, 0, 0, 1, 0);  expectLit(2, K_RDDAT, 0);
    applyStimulus(0, 0, 0, 0, 0, 1, 31); expectLit(2, K_RDDAT, 0);
    applyStimulus(0, 0, 0, 0, 0, 1, 63); expectLit(2, K_RDDAT, 0);
    idle(3);

    // Abort a fill at its 21st write with reset; untouched words keep data.
    applyStimulus(0, 0, 1, 0, 5, 0, 0);
    applyStimulus(0, 0, 1, 40, 9, 0, 0);
    applyStimulus(0, 1, 0, 0, 0, 0, 0);
    s = cyc;
    idle(20);
    applyStimulus(1, 0, 0, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 0, 0, 0);
    expectLit(0, K_BUSY, 0);
    expectLit(0, K_DONE, 0);
    expectLit(0, K_WENA, 1);
    expectLit(0, K_ADR, 0);
    expectLit(s + 65 - cyc, K_DONE, 0);
    applyStimulus(0, 0, 0, 0, 0, 1, 0);  expectLit(2, K_RDDAT, 0);
    applyStimulus(0, 0, 0, 0, 0, 1, 40); expectLit(2, K_RDDAT, 9);
    idle(60);
    applyStimulus(0, 1, 0, 0, 0, 0, 0);
    expectLit(1, K_ADR, 0);
    expectLit(1, K_WENA, 0);
    expectLit(1, K_BUSY, 1);
    expectLit(65, K_DONE, 1);
    idle(68);

    for (int i = 0; i < 2000; i++) begin
      r  = ($urandom_range(0, 299) == 0);
      cs = ($urandom_range(0, 199) == 0);
      wv = 1'($urandom_range(0, 1));
      rv = 1'($urandom_range(0, 1));
      wa = ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, 7)) : int'($urandom_range(0, 63));
      ra = ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, 7)) : int'($urandom_range(0, 63));
      wd = int'($urandom_range(0, 63));
      applyStimulus(r, cs, wv, wa, wd, rv, ra);
    end
    idle(4);
    @(negedge clk);
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
